seg7_scan_driver: RTL and testbench

Multiplexed seven-segment display driver for the board's 4-digit common-anode display. Accepts packed BCD digits from the decade-counter chain, snapshots them on a load strobe, and time-multiplexes one digit at a time onto the shared active-low cathode bus. It sits between the counter cascade and the board pins and is the sole owner of the anode and segment outputs.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_decode.sv | 30 +++
 rtl/seg7_scan_driver.sv | 125 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: active-low digit patterns
// (bit 0 = segment a) and the counter width helper.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Bits needed to count 0..slots-1, never less than one.
    function automatic int unsigned slot_width(input int unsigned slots);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < slots) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low seven-segment pattern; codes 10-15 and the blank flag
// both turn every segment off.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] pattern_c
);

    always_comb begin
        pattern_c = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    pattern_c = SEG_0;
                4'd1:    pattern_c = SEG_1;
                4'd2:    pattern_c = SEG_2;
                4'd3:    pattern_c = SEG_3;
                4'd4:    pattern_c = SEG_4;
                4'd5:    pattern_c = SEG_5;
                4'd6:    pattern_c = SEG_6;
                4'd7:    pattern_c = SEG_7;
                4'd8:    pattern_c = SEG_8;
                4'd9:    pattern_c = SEG_9;
                default: pattern_c = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode display driver: snapshots BCD digits on load and
// scans them one slot at a time. Define SEG7_SCAN_LZ_BLANK_EN for leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 50000
) (
    input  logic                clk,
    input  logic                grst,
    input  logic                enable,
    input  logic                load,
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic [DIGITS-1:0]   dp_in,
    output logic [DIGITS-1:0]   an,
    output logic [6:0]          seg,
    output logic                dp,
    output logic                frame_tick
);

    localparam int unsigned   PW         = slot_width(PRESCALE);
    localparam int unsigned   IW         = slot_width(DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    logic [PW-1:0]       presc;
    logic [IW-1:0]       idx;
    logic                load_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [DIGITS-1:0]   dp_q;
    logic [4*DIGITS-1:0] snap;
    logic [DIGITS-1:0]   snap_dp;
    logic                wrap_q;

    logic                slot_tick_c;
    logic                wrap_c;
    logic [3:0]          digit_c;
    logic                sel_dp_c;
    logic                blank_c;
    logic [DIGITS-1:0]   an_c;
    logic [DIGITS-1:0]   lz_c;
    logic [6:0]          seg_c;

    assign slot_tick_c = enable && (presc == PRESC_LAST);
    assign wrap_c      = slot_tick_c && (idx == IDX_LAST);

`ifdef SEG7_SCAN_LZ_BLANK_EN
    // Blank run of zeros from the top digit down; digit 0 is always shown.
    always_comb begin
        logic run;
        lz_c = '0;
        run  = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            run     = run && (snap[4*k +: 4] == 4'd0);
            lz_c[k] = run;
        end
    end
`else
    assign lz_c = '0;
`endif

    // Select the scanned digit; anode stays off while the prescaler is 0.
    always_comb begin
        digit_c  = '0;
        sel_dp_c = 1'b0;
        blank_c  = 1'b0;
        an_c     = '1;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (idx == IW'(k)) begin
                digit_c  = snap[4*k +: 4];
                sel_dp_c = snap_dp[k];
                blank_c  = lz_c[k];
                an_c[k]  = (presc == '0);
            end
        end
    end

    seg7_decode u_decode (
        .bcd       (digit_c),
        .blank     (blank_c),
        .pattern_c (seg_c)
    );

    always_ff @(posedge clk) begin
        if (grst) begin
            presc      <= '0;
            idx        <= '0;
            load_q     <= 1'b0;
            bcd_q      <= '0;
            dp_q       <= '0;
            snap       <= '0;
            snap_dp    <= '0;
            wrap_q     <= 1'b0;
            an         <= '1;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            if (slot_tick_c) begin
                presc <= '0;
                idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else if (enable) begin
                presc <= presc + PW'(1);
            end

            // Two-stage capture so the snapshot only changes as a whole word.
            load_q <= load;
            if (load) begin
                bcd_q <= bcd_in;
                dp_q  <= dp_in;
            end
            if (load_q) begin
                snap    <= bcd_q;
                snap_dp <= dp_q;
            end

            an         <= an_c;
            seg        <= seg_c;
            dp         <= ~sel_dp_c;
            wrap_q     <= wrap_c;
            frame_tick <= wrap_q;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with DIGITS=4, PRESCALE=4.
`timescale 1ns/1ps
module tb_seg7_scan_driver;

    localparam int D = 4;
    localparam int P = 4;

    logic        clk    = 1'b0;
    logic        grst   = 1'b1;
    logic        enable = 1'b0;
    logic        load   = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in  = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(D), .PRESCALE(P)) dut (
        .clk        (clk),
        .grst       (grst),
        .enable     (enable),
        .load       (load),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
    } out_t;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  dpv;
        logic [27:0] segs;   // expected pattern of digit k at [7k +: 7]
    } vec_t;

    out_t exp_q[$];
    out_t last_exp;
    vec_t vecs[6];
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference model state
    int          m_presc = 0;
    int          m_idx   = 0;
    logic [15:0] m_snap  = '0;
    logic [15:0] m_bcdq  = '0;
    logic [3:0]  m_sdp   = '0;
    logic [3:0]  m_dpq   = '0;
    logic        m_loadq = 1'b0;
    logic        m_wrapq = 1'b0;

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Predict the outputs produced at this edge and advance the model.
    task automatic model_step();
        out_t       o;
        logic [3:0] dg;
        logic       blank;
        if (grst) begin
            m_presc = 0; m_idx = 0; m_snap = '0; m_sdp = '0;
            m_bcdq = '0; m_dpq = '0; m_loadq = 1'b0; m_wrapq = 1'b0;
            o.an = 4'hF; o.seg = 7'h7F; o.dp = 1'b1; o.ft = 1'b0;
        end else begin
            dg    = m_snap[m_idx*4 +: 4];
            blank = 1'b0;
`ifdef SEG7_SCAN_LZ_BLANK_EN
            begin
                logic lead;
                lead = (dg == 4'd0) && (m_idx != 0);
                for (int k = 3; k > m_idx; k--) lead = lead && (m_snap[k*4 +: 4] == 4'd0);
                blank = lead;
            end
`endif
            o.an  = (m_presc == 0) ? 4'hF : ~(4'b0001 << m_idx);
            o.seg = blank ? 7'h7F : ref_seg(dg);
            o.dp  = ~m_sdp[m_idx];
            o.ft  = m_wrapq;
            m_wrapq = enable && (m_presc == P-1) && (m_idx == D-1);
            if (enable) begin
                if (m_presc == P-1) begin
                    m_presc = 0;
                    m_idx   = (m_idx + 1) % D;
                end else begin
                    m_presc++;
                end
            end
            if (m_loadq) begin
                m_snap = m_bcdq;
                m_sdp  = m_dpq;
            end
            m_loadq = load;
            if (load) begin
                m_bcdq = bcd_in;
                m_dpq  = dp_in;
            end
        end
        exp_q.push_back(o);
    endtask

    // One clock: model at the edge, compare DUT on the falling edge.
    task automatic tick();
        out_t e;
        @(posedge clk);
        model_step();
        @(negedge clk);
        e = exp_q.pop_front();
        last_exp = e;
        chk("scoreboard", 32'({an, seg, dp, frame_tick}), 32'(e));
    endtask

    task automatic run_vector(input vec_t v);
        logic [6:0] seen_seg [4];
        logic       seen_dp  [4];
        int         lit      [4];
        logic [3:0] sel;
        logic       dp_exp;
        bcd_in = v.bcd;
        dp_in  = v.dpv;
        load   = 1'b1;
        tick();
        load = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 4; k++) begin
            seen_seg[k] = 7'h55; seen_dp[k] = 1'bx; lit[k] = 0;
        end
        repeat (32) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                sel = ~(4'b0001 << k);
                if (an == sel) begin
                    lit[k]++;
                    seen_seg[k] = seg;
                    seen_dp[k]  = dp;
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            dp_exp = ~v.dpv[k];
            chk($sformatf("vec_%04h_seg%0d", v.bcd, k), 32'(seen_seg[k]), 32'(v.segs[7*k +: 7]));
            chk($sformatf("vec_%04h_dp%0d", v.bcd, k), 32'(seen_dp[k]), 32'(dp_exp));
            chk($sformatf("vec_%04h_lit%0d", v.bcd, k), 32'(lit[k]), 32'd6);
        end
    endtask

    initial begin
        int   cnt;
        logic found;
        out_t frozen;

        vecs[0] = '{bcd: 16'h1234, dpv: 4'b0000, segs: {7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[1] = '{bcd: 16'h9999, dpv: 4'b0000, segs: {7'h10, 7'h10, 7'h10, 7'h10}};
        vecs[2] = '{bcd: 16'h5B78, dpv: 4'b0100, segs: {7'h12, 7'h7F, 7'h78, 7'h00}};
`ifdef SEG7_SCAN_LZ_BLANK_EN
        vecs[3] = '{bcd: 16'h0050, dpv: 4'b0000, segs: {7'h7F, 7'h7F, 7'h12, 7'h40}};
        vecs[4] = '{bcd: 16'h0000, dpv: 4'b1000, segs: {7'h7F, 7'h7F, 7'h7F, 7'h40}};
`else
        vecs[3] = '{bcd: 16'h0050, dpv: 4'b0000, segs: {7'h40, 7'h40, 7'h12, 7'h40}};
        vecs[4] = '{bcd: 16'h0000, dpv: 4'b1000, segs: {7'h40, 7'h40, 7'h40, 7'h40}};
`endif
        vecs[5] = '{bcd: 16'h6086, dpv: 4'b0011, segs: {7'h02, 7'h40, 7'h00, 7'h02}};

        // Reset held for three cycles, then released
        repeat (3) begin
            tick();
            chk("reset_outputs", 32'({an, seg, dp, frame_tick}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
        end
        grst = 1'b0;
        #1;
        chk("reset_first_cycle_after", 32'({an, seg, dp, frame_tick}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
        enable = 1'b1;

        for (int i = 0; i < 6; i++) run_vector(vecs[i]);

        // bcd_in changes without load must not reach the display
        bcd_in = 16'h1111;
        repeat (20) begin
            tick();
            if (an == 4'b1110) chk("isolation_digit0", 32'(seg), 32'h02);
        end

        // frame_tick period
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            tick();
            found = frame_tick;
        end
        chk("frame_tick_seen", 32'(found), 32'd1);
        repeat (2) begin
            cnt = 0; found = 1'b0;
            while (!found && cnt < 40) begin
                tick();
                cnt++;
                found = frame_tick;
            end
            chk("frame_tick_period", 32'(cnt), 32'd16);
        end

        // Enable low mid-slot freezes the display
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            tick();
            found = (an == 4'b1011);
        end
        chk("reach_digit2", 32'(found), 32'd1);
        enable = 1'b0;
        tick();
        frozen = last_exp;
        repeat (10) begin
            tick();
            chk("freeze_an", 32'(an), 32'(frozen.an));
            chk("freeze_seg", 32'(seg), 32'(frozen.seg));
            chk("freeze_no_ft", 32'(frame_tick), 32'd0);
        end
        enable = 1'b1;

        // Reset mid-slot: outputs reset next cycle, snapshot lost, scan from digit 0
        repeat (2) tick();
        grst = 1'b1;
        tick();
        chk("midreset_outputs", 32'({an, seg, dp, frame_tick}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
        grst = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            found = (an != 4'hF);
        end
        chk("restart_lit", 32'(found), 32'd1);
        chk("restart_digit0_an", 32'(an), 32'(4'b1110));
        chk("restart_digit0_seg", 32'(seg), 32'h40);

        // Random traffic against the model
        repeat (400) begin
            enable = ($urandom_range(0, 9) != 0);
            load   = ($urandom_range(0, 5) == 0);
            bcd_in = 16'($urandom);
            dp_in  = 4'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
